num_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 8-digit common-segment 7-segment display on the lab board.
- Holds one 4-bit value per digit, written by a simple register-write port from the lab top.
- Rotates the active digit select at a programmable refresh rate and drives the matching segment pattern.
- Replaces the fixed single-digit drive with full 8-digit sequencing.

---
 rtl/num_scan_ctrl_pkg.sv | 20 ++
 rtl/num_scan_ctrl_seg7_decode.sv | 26 ++
 rtl/num_scan_ctrl.sv | 86 ++++++++
 tb/tb_num_scan_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/num_scan_ctrl_pkg.sv
// Shared constants for the 8-digit 7-segment scan controller.
// Segment bit order is a..g with a in bit 6; digit selects are active-low.
package num_scan_ctrl_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [7:0] CSN_OFF   = 8'hFF;

    localparam logic [3:0] MAX_DIGIT_VAL = 4'd9;

endpackage

// File: rtl/num_scan_ctrl_seg7_decode.sv
// Combinational BCD digit to 7-segment lookup; values above 9 decode to blank.
module seg7_decode
    import num_scan_ctrl_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/num_scan_ctrl.sv
// Time-multiplexed scan controller for the 8-digit 7-segment display.
// Digit selects and segments are registered one cycle behind scan_idx and the digit/mask state.
module num_scan_ctrl
    import num_scan_ctrl_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV   = 16'd50000,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [2:0]            wr_idx,
    input  logic [3:0]            wr_data,
    input  logic                  en_wr,
    input  logic [NUM_DIGITS-1:0] en_data,
    output logic [NUM_DIGITS-1:0] num_csn,
    output logic [6:0]            num_a_g,
    output logic [2:0]            scan_idx
);

    localparam logic [NUM_DIGITS-1:0] SelOne = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [15:0]           div_cnt_q, div_cnt_d;
    logic [2:0]            scan_idx_q, scan_idx_d;
    logic [3:0]            digit_q [NUM_DIGITS];
    logic [3:0]            digit_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [NUM_DIGITS-1:0] csn_q, csn_d;
    logic [6:0]            seg_q, seg_d;
    logic [3:0]            cur_digit;
    logic [6:0]            cur_seg;

    assign cur_digit = digit_q[scan_idx_q];

    seg7_decode u_seg7_decode (
        .digit_i (cur_digit),
        .seg_o   (cur_seg)
    );

    always_comb begin
        div_cnt_d  = div_cnt_q + 16'd1;
        scan_idx_d = scan_idx_q;
        if (div_cnt_q == SCAN_DIV - 16'd1) begin
            div_cnt_d  = '0;
            scan_idx_d = scan_idx_q + 3'd1;
        end

        digit_d = digit_q;
        // Out-of-range values are dropped so the display never shows a blank digit by accident.
        if (wr_en && (wr_data <= MAX_DIGIT_VAL)) begin
            digit_d[wr_idx] = wr_data;
        end

        mask_d = en_wr ? en_data : mask_q;

        csn_d = CSN_OFF;
        seg_d = SEG_BLANK;
        if (mask_q[scan_idx_q]) begin
            csn_d = ~(SelOne << scan_idx_q);
            seg_d = cur_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q  <= '0;
            scan_idx_q <= '0;
            digit_q    <= '{default: '0};
            mask_q     <= '0;
            csn_q      <= CSN_OFF;
            seg_q      <= SEG_BLANK;
        end else begin
            div_cnt_q  <= div_cnt_d;
            scan_idx_q <= scan_idx_d;
            digit_q    <= digit_d;
            mask_q     <= mask_d;
            csn_q      <= csn_d;
            seg_q      <= seg_d;
        end
    end

    assign num_csn  = csn_q;
    assign num_a_g  = seg_q;
    assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_num_scan_ctrl.sv
// Scoreboard bench: a cycle-count reference model queues expected outputs, a monitor compares.
module tb_num_scan_ctrl;

    localparam int Div = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [3:0] wr_data;
    logic       en_wr;
    logic [7:0] en_data;
    logic [7:0] num_csn;
    logic [6:0] num_a_g;
    logic [2:0] scan_idx;

    num_scan_ctrl #(
        .SCAN_DIV   (16'(Div)),
        .NUM_DIGITS (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .en_wr    (en_wr),
        .en_data  (en_data),
        .num_csn  (num_csn),
        .num_a_g  (num_a_g),
        .scan_idx (scan_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] csn;
        logic [6:0] seg;
        logic [2:0] scan;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    // Reference model: the active digit is just (cycles since reset / Div) mod 8.
    int         m_cycles = 0;
    int         m_digit [8];
    logic [7:0] m_mask = 8'h00;

    initial begin
        forever begin
            exp_t e;
            int   cur;
            @(posedge clk);
            if (reset) begin
                e.csn = 8'hFF;
                e.seg = 7'b0000000;
                e.scan = 3'd0;
                m_cycles = 0;
                m_mask = 8'h00;
                for (int i = 0; i < 8; i++) m_digit[i] = 0;
            end else begin
                cur = (m_cycles / Div) % 8;
                if (m_mask[cur]) begin
                    e.csn = 8'hFF ^ (8'(1) << cur);
                    e.seg = seg_tab[m_digit[cur]];
                end else begin
                    e.csn = 8'hFF;
                    e.seg = 7'b0000000;
                end
                m_cycles++;
                e.scan = 3'((m_cycles / Div) % 8);
                if (wr_en && wr_data < 4'd10) m_digit[wr_idx] = int'(wr_data);
                if (en_wr) m_mask = en_data;
            end
            q.push_back(e);
        end
    end

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp += 4;
                if (num_csn !== e.csn) begin
                    n_bad++;
                    $display("FAIL csn t=%0t got %b want %b", $time, num_csn, e.csn);
                end
                if (num_a_g !== e.seg) begin
                    n_bad++;
                    $display("FAIL seg t=%0t got %b want %b", $time, num_a_g, e.seg);
                end
                if (scan_idx !== e.scan) begin
                    n_bad++;
                    $display("FAIL scan t=%0t got %0d want %0d", $time, scan_idx, e.scan);
                end
                if ($countones(~num_csn) > 1) begin
                    n_bad++;
                    $display("FAIL onehot t=%0t got %b want at most one low", $time, num_csn);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b0; en_wr = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wr_digit(input logic [2:0] idx, input logic [3:0] val);
        wr_en = 1'b1; wr_idx = idx; wr_data = val; en_wr = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wr_mask(input logic [7:0] m);
        en_wr = 1'b1; en_data = m; wr_en = 1'b0;
        @(negedge clk);
        en_wr = 1'b0;
    endtask

    task automatic wait_scan(input logic [2:0] target);
        int k;
        for (k = 0; k < 64 && scan_idx !== target; k++) @(negedge clk);
        n_cmp++;
        if (scan_idx !== target) begin
            n_bad++;
            $display("FAIL wait_scan got %0d want %0d", scan_idx, target);
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0; en_wr = 1'b0; en_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(40);

        for (int i = 0; i < 8; i++) wr_digit(3'(i), 4'(7 - i));
        wr_mask(8'hFF);
        idle(40);

        wr_digit(3'd2, 4'd5);
        idle(10);
        wr_digit(3'd2, 4'd12);
        idle(34);
        wr_digit(3'd2, 4'd9);
        idle(34);

        wr_mask(8'b0000_0101);
        idle(40);

        wr_mask(8'hFF);
        wait_scan(3'd3);
        idle(1);
        wr_digit(3'd3, 4'd8);
        idle(20);

        wait_scan(3'd5);
        idle(1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        wr_mask(8'hFF);
        idle(40);

        // Random traffic, including occasional out-of-range values, mask changes and resets.
        for (int i = 0; i < 400; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_idx  = 3'($urandom_range(0, 7));
            wr_data = 4'($urandom_range(0, 15));
            en_wr   = ($urandom_range(0, 15) == 0);
            en_data = 8'($urandom);
            reset   = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        idle(5);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
